locker_key_entry: RTL and testbench

Upstream front end for `digital_locker`: converts four raw push buttons (digit 0, digit 1, enter, clear) into the serial `pwd_in` bit stream and the `submit` pulse that the locker consumes. Each button is synchronised and debounced; digits are collected into a PWD_LEN-bit entry buffer. On enter, the buffer is replayed to the locker one bit per clock, first-pressed digit first. Clear aborts entry and issues `submit` so the locker returns to its locked state.

---
 rtl/locker_key_entry.sv | 196 +++++++++++++++++++
 tb/tb_locker_key_entry.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/locker_key_entry.sv
// ---------------------------------------------------------------------------
// locker_key_entry
//
// Push-button front end for digital_locker. Four raw buttons are each
// synchronised and debounced into a one-cycle press event. Digit presses are
// collected into a PWD_LEN-bit entry buffer. Enter replays the buffer to the
// locker one bit per clock, first-entered digit first. Clear aborts entry and
// pulses submit so the locker re-locks.
//
// Parameters
//   PWD_LEN          digits per password (2..16)
//   DEBOUNCE_CYCLES  consecutive stable cycles to accept a level change (>=2)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   key0_btn     raw digit-0 button (asynchronous, bouncy)
//   key1_btn     raw digit-1 button (asynchronous, bouncy)
//   enter_btn    raw enter button
//   clear_btn    raw clear button
//   pwd_out      serial password bit to locker pwd_in
//   pwd_stream   high during the PWD_LEN streaming cycles
//   submit       one-cycle pulse to locker submit
//   digit_count  digits currently buffered
//   buf_full     digit_count == PWD_LEN
//   entry_err    one-cycle pulse: enter pressed with buffer not full
// ---------------------------------------------------------------------------
module locker_key_entry #(
    parameter int PWD_LEN         = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         key0_btn,
    input  logic                         key1_btn,
    input  logic                         enter_btn,
    input  logic                         clear_btn,
    output logic                         pwd_out,
    output logic                         pwd_stream,
    output logic                         submit,
    output logic [$clog2(PWD_LEN+1)-1:0] digit_count,
    output logic                         buf_full,
    output logic                         entry_err
);

    localparam int CNT_W = $clog2(PWD_LEN + 1);
    localparam int IDX_W = $clog2(PWD_LEN);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);

    localparam logic [CNT_W-1:0] FULL     = CNT_W'(PWD_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PWD_LEN - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

    // Button lane indices within the packed per-button vectors.
    localparam int B_KEY0  = 0;
    localparam int B_KEY1  = 1;
    localparam int B_ENTER = 2;
    localparam int B_CLEAR = 3;

    typedef enum logic {
        COLLECT = 1'b0,
        STREAM  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Synchronise, debounce and edge-detect all four buttons.
    // ------------------------------------------------------------------
    logic [3:0]           raw;
    logic [3:0]           sync1;
    logic [3:0]           sync2;
    logic [3:0]           db;
    logic [3:0]           db_d;
    logic [3:0]           evt;
    logic [3:0][DB_W-1:0] db_cnt;

    assign raw = {clear_btn, enter_btn, key1_btn, key0_btn};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, independent of statement
    // order within the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            db     <= '0;
            db_d   <= '0;
            evt    <= '0;
            db_cnt <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db_d  <= db;
            // db_d lags db by one edge, so the press event is registered one
            // cycle after db rises; releases produce nothing.
            evt   <= db & ~db_d;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    // This is the DEBOUNCE_CYCLES-th consecutive differing sample.
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    logic key0_evt;
    logic key1_evt;
    logic enter_evt;
    logic clear_evt;

    assign key0_evt  = evt[B_KEY0];
    assign key1_evt  = evt[B_KEY1];
    assign enter_evt = evt[B_ENTER];
    assign clear_evt = evt[B_CLEAR];

    // ------------------------------------------------------------------
    // Entry / stream controller.
    // The buffer shifts left on entry, so the first-entered digit ends up in
    // the MSB; streaming keeps shifting left and always emits the MSB.
    // ------------------------------------------------------------------
    state_t             state;
    logic [PWD_LEN-1:0] buffer;
    logic [IDX_W-1:0]   idx;

    assign buf_full = (digit_count == FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= COLLECT;
            buffer      <= '0;
            digit_count <= '0;
            idx         <= '0;
            pwd_out     <= 1'b0;
            pwd_stream  <= 1'b0;
            submit      <= 1'b0;
            entry_err   <= 1'b0;
        end else begin
            submit    <= 1'b0;
            entry_err <= 1'b0;

            if (clear_evt) begin
                // Clear overrides everything, including a stream in progress
                // and any digit/enter event arriving in the same cycle.
                state       <= COLLECT;
                buffer      <= '0;
                digit_count <= '0;
                idx         <= '0;
                pwd_out     <= 1'b0;
                pwd_stream  <= 1'b0;
                submit      <= 1'b1;
            end else begin
                case (state)
                    COLLECT: begin
                        if (enter_evt) begin
                            if (buf_full) begin
                                state      <= STREAM;
                                idx        <= '0;
                                pwd_stream <= 1'b1;
                                pwd_out    <= buffer[PWD_LEN-1];
                                buffer     <= {buffer[PWD_LEN-2:0], 1'b0};
                            end else begin
                                entry_err <= 1'b1;
                            end
                        end else if ((key0_evt ^ key1_evt) && !buf_full) begin
                            // Exactly one digit key: key1_evt is the digit value.
                            buffer      <= {buffer[PWD_LEN-2:0], key1_evt};
                            digit_count <= digit_count + CNT_W'(1);
                        end
                    end

                    STREAM: begin
                        if (idx == IDX_LAST) begin
                            state       <= COLLECT;
                            buffer      <= '0;
                            digit_count <= '0;
                            idx         <= '0;
                            pwd_out     <= 1'b0;
                            pwd_stream  <= 1'b0;
                        end else begin
                            idx     <= idx + IDX_W'(1);
                            pwd_out <= buffer[PWD_LEN-1];
                            buffer  <= {buffer[PWD_LEN-2:0], 1'b0};
                        end
                    end

                    default: state <= COLLECT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_locker_key_entry.sv
// ---------------------------------------------------------------------------
// Testbench for locker_key_entry (PWD_LEN=4, DEBOUNCE_CYCLES=4).
// Directed scenarios followed by random button operations, all checked
// against a queue-based model of the buffered digits.
// ---------------------------------------------------------------------------
module tb_locker_key_entry;

    localparam int PWD_LEN = 4;
    localparam int DEB     = 4;
    // Edges from the first edge sampling a clean press to the visible effect
    // (count change, stream start, submit or entry_err): DEB+2 for the event
    // plus one for the controller.
    localparam int LAT     = DEB + 3;

    logic       clk;
    logic       rst;
    logic       key0_btn, key1_btn, enter_btn, clear_btn;
    logic       pwd_out, pwd_stream, submit, buf_full, entry_err;
    logic [2:0] digit_count;

    locker_key_entry #(.PWD_LEN(PWD_LEN), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk        (clk),
        .rst        (rst),
        .key0_btn   (key0_btn),
        .key1_btn   (key1_btn),
        .enter_btn  (enter_btn),
        .clear_btn  (clear_btn),
        .pwd_out    (pwd_out),
        .pwd_stream (pwd_stream),
        .submit     (submit),
        .digit_count(digit_count),
        .buf_full   (buf_full),
        .entry_err  (entry_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: digits currently buffered, first-entered at index 0.
    bit q[$];

    // Per-operation observation record.
    logic signed [31:0] mon_cycle, t_first, t_sub, got_len, got_bits;
    logic signed [31:0] n_err, n_sub, bad_idle;
    logic [2:0]         prev_count;
    logic               prev_stream;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic mon_reset();
        mon_cycle   = 0;
        t_first     = -1;
        t_sub       = -1;
        got_len     = 0;
        got_bits    = 0;
        n_err       = 0;
        n_sub       = 0;
        bad_idle    = 0;
        prev_count  = digit_count;
        prev_stream = pwd_stream;
    endtask

    // Apply button mask {clear, enter, key1, key0} for one edge, then observe.
    task automatic step(input logic [3:0] m);
        {clear_btn, enter_btn, key1_btn, key0_btn} = m;
        @(posedge clk);
        #1;
        if (t_first < 0 && (digit_count !== prev_count || (pwd_stream && !prev_stream)
                            || submit || entry_err))
            t_first = mon_cycle;
        if (submit && t_sub < 0) t_sub = mon_cycle;
        if (submit) n_sub++;
        if (entry_err) n_err++;
        if (pwd_stream) begin
            got_bits = {got_bits[30:0], pwd_out};
            got_len++;
        end else if (pwd_out !== 1'b0) begin
            bad_idle = 1;
        end
        prev_count  = digit_count;
        prev_stream = pwd_stream;
        mon_cycle++;
    endtask

    task automatic check_mon(input string tag, input logic signed [31:0] et,
                             input logic signed [31:0] elen, input logic signed [31:0] ebits,
                             input logic signed [31:0] eerr, input logic signed [31:0] esub,
                             input logic signed [31:0] etsub);
        check({tag, " first-effect cycle"}, t_first, et);
        check({tag, " stream length"}, got_len, elen);
        check({tag, " stream bits"}, got_bits, ebits);
        check({tag, " entry_err pulses"}, n_err, eerr);
        check({tag, " submit pulses"}, n_sub, esub);
        check({tag, " submit cycle"}, t_sub, etsub);
        check({tag, " pwd_out idle"}, bad_idle, 0);
        check({tag, " digit_count"}, 32'(digit_count), 32'(q.size()));
        check({tag, " buf_full"}, 32'(buf_full), 32'(q.size() == PWD_LEN));
    endtask

    function automatic logic signed [31:0] q_bits();
        logic signed [31:0] b = 0;
        foreach (q[i]) b = {b[30:0], q[i]};
        return b;
    endfunction

    // One clean press of button `which` (0 key0, 1 key1, 2 enter, 3 clear).
    task automatic do_op(input int which, input int hold, input string tag);
        logic signed [31:0] et = -1, elen = 0, ebits = 0, eerr = 0, esub = 0, etsub = -1;
        case (which)
            0, 1: if (q.size() < PWD_LEN) begin
                q.push_back(which[0]);
                et = LAT;
            end
            2: begin
                et = LAT;
                if (q.size() == PWD_LEN) begin
                    elen  = PWD_LEN;
                    ebits = q_bits();
                    q.delete();
                end else begin
                    eerr = 1;
                end
            end
            default: begin
                et    = LAT;
                esub  = 1;
                etsub = LAT;
                q.delete();
            end
        endcase
        mon_reset();
        for (int c = 0; c < hold; c++) step(4'b0001 << which);
        for (int c = 0; c < 14; c++) step(4'b0000);
        check_mon(tag, et, elen, ebits, eerr, esub, etsub);
    endtask

    initial begin
        bit bounce[10] = '{1, 0, 1, 1, 0, 1, 0, 0, 1, 0};

        {clear_btn, enter_btn, key1_btn, key0_btn} = 4'b0000;
        rst = 1'b1;
        mon_reset();
        for (int c = 0; c < 3; c++) step(4'b0000);
        check("reset pwd_out", 32'(pwd_out), 0);
        check("reset pwd_stream", 32'(pwd_stream), 0);
        check("reset submit", 32'(submit), 0);
        check("reset digit_count", 32'(digit_count), 0);
        check("reset buf_full", 32'(buf_full), 0);
        check("reset entry_err", 32'(entry_err), 0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) step(4'b0000);

        // Clean entry 1,1,0,0; fifth digit ignored; enter streams 1100.
        do_op(1, 8, "d1 key1");
        do_op(1, 8, "d2 key1");
        do_op(0, 8, "d3 key0");
        do_op(0, 8, "d4 key0");
        do_op(1, 8, "fifth digit");
        do_op(2, 8, "enter stream");

        // Bouncing key1, then stable high: one event once stable for DEB.
        mon_reset();
        for (int c = 0; c < 10; c++) step({2'b00, bounce[c], 1'b0});
        for (int c = 0; c < 8; c++) step(4'b0010);
        for (int c = 0; c < 14; c++) step(4'b0000);
        q.push_back(1'b1);
        check_mon("bounce", 10 + LAT, 0, 0, 0, 0, -1);

        // Isolated 3-cycle glitch on key0: no event.
        mon_reset();
        for (int c = 0; c < 3; c++) step(4'b0001);
        for (int c = 0; c < 14; c++) step(4'b0000);
        check_mon("glitch", -1, 0, 0, 0, 0, -1);

        // Two digits, then enter: entry_err only.
        do_op(0, 7, "second digit");
        do_op(2, 7, "enter short");

        // key0 and key1 events in the same cycle: ignored.
        mon_reset();
        for (int c = 0; c < 8; c++) step(4'b0011);
        for (int c = 0; c < 14; c++) step(4'b0000);
        check_mon("both keys", -1, 0, 0, 0, 0, -1);

        // Clear and key1 in the same cycle: buffer empties, submit pulses.
        mon_reset();
        for (int c = 0; c < 8; c++) step(4'b1010);
        for (int c = 0; c < 14; c++) step(4'b0000);
        q.delete();
        check_mon("clear+key1", LAT, 0, 0, 0, 1, LAT);

        // Clear lands after the second streamed bit.
        do_op(1, 6, "f1");
        do_op(0, 6, "f2");
        do_op(1, 6, "f3");
        do_op(1, 6, "f4");
        mon_reset();
        for (int c = 0; c < 2; c++) step(4'b0100);
        for (int c = 2; c < 8; c++) step(4'b1100);
        for (int c = 8; c < 10; c++) step(4'b1000);
        for (int c = 0; c < 14; c++) step(4'b0000);
        q.delete();
        check_mon("clear mid-stream", LAT, 2, 2'b10, 0, 1, LAT + 2);

        // Reset for one cycle mid-stream.
        do_op(0, 6, "g1");
        do_op(1, 6, "g2");
        do_op(0, 6, "g3");
        do_op(1, 6, "g4");
        mon_reset();
        for (int c = 0; c < LAT + 1; c++) step(4'b0100);
        check("rst-mid stream active", 32'(pwd_stream), 1);
        rst = 1'b1;
        step(4'b0000);
        rst = 1'b0;
        q.delete();
        check("rst-mid pwd_out", 32'(pwd_out), 0);
        check("rst-mid pwd_stream", 32'(pwd_stream), 0);
        check("rst-mid submit", 32'(submit), 0);
        check("rst-mid digit_count", 32'(digit_count), 0);
        check("rst-mid buf_full", 32'(buf_full), 0);
        check("rst-mid entry_err", 32'(entry_err), 0);
        mon_reset();
        for (int c = 0; c < 14; c++) step(4'b0000);
        check_mon("after rst", -1, 0, 0, 0, 0, -1);

        // key1 held through reset: one event after release of reset.
        rst = 1'b1;
        for (int c = 0; c < 3; c++) step(4'b0010);
        rst = 1'b0;
        mon_reset();
        for (int c = 0; c < 10; c++) step(4'b0010);
        for (int c = 0; c < 14; c++) step(4'b0000);
        q.push_back(1'b1);
        check_mon("held through rst", LAT, 0, 0, 0, 0, -1);

        // Random clean button operations.
        for (int n = 0; n < 40; n++) begin
            int r     = int'($urandom_range(0, 99));
            int which = (r < 35) ? 0 : (r < 70) ? 1 : (r < 88) ? 2 : 3;
            do_op(which, int'($urandom_range(6, 10)), $sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
